// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE squeeze path.
// Lane and block geometry for both SHAKE variants.
package shake_pkg;

  typedef enum logic {
    SHAKE128 = 1'b0,
    SHAKE256 = 1'b1
  } mode_t;

  localparam int WORDS_128 = 21;
  localparam int WORDS_256 = 17;
  localparam int LANE_W    = 64;

  typedef enum logic [1:0] {
    IDLE,
    READY,
    HOLD,
    DONE
  } obuf_state_t;

  function automatic logic [4:0] blk_words(mode_t m);
    return (m == SHAKE256) ? 5'(WORDS_256)
                           : 5'(WORDS_128);
  endfunction

endpackage

// File: rtl/output_buffer_if.sv
// Handshake bundle between the squeeze dump FSM
// and the output buffer.
interface output_buffer_if #(
  parameter int WORD_W = 64,
  parameter int RATE_W = 1344,
  parameter int LEN_W  = 32
);
  logic              mode_in;
  logic              out_len_load;
  logic [LEN_W-1:0]  out_len_in;
  logic              we_in;
  logic              counter_load;
  logic              counter_rst;
  logic              shift_en;
  logic [RATE_W-1:0] state_in;
  logic [WORD_W-1:0] data_out;
  logic              empty;
  logic              last_out;
  logic              done;
  logic              need_block;

  modport master (
    output mode_in, out_len_load, out_len_in,
    output we_in, counter_load, counter_rst,
    output shift_en, state_in,
    input  data_out, empty, last_out,
    input  done, need_block
  );

  modport slave (
    input  mode_in, out_len_load, out_len_in,
    input  we_in, counter_load, counter_rst,
    input  shift_en, state_in,
    output data_out, empty, last_out,
    output done, need_block
  );
endinterface

// File: rtl/word_down_counter.sv
// Loadable down counter that saturates at zero.
// Priority: clear, then load, then decrement.
module word_down_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/output_buffer.sv
// Parallel-in/serial-out block buffer feeding the
// squeeze dump FSM one lane per shift.
module output_buffer
  import shake_pkg::*;
#(
  parameter int WORD_W = LANE_W,
  parameter int RATE_W = 1344,
  parameter int LEN_W  = 32
) (
  input  logic clk,
  input  logic rst,
  output_buffer_if.slave bus
);
  localparam int KEEP_256 = WORDS_256 * WORD_W;
  localparam logic [RATE_W-1:0] MASK_256 =
    {{(RATE_W-KEEP_256){1'b0}}, {KEEP_256{1'b1}}};

  obuf_state_t       state_q;
  logic [RATE_W-1:0] buf_q, buf_d;
  logic [4:0]        wc_cnt, wc_val;
  logic              wc_zero;
  logic [LEN_W-1:0]  rem_cnt, blk_len;
  logic              rem_zero;
  logic              wc_clr, wc_load, shift_ok;

  assign blk_len =
    LEN_W'(blk_words(mode_t'(bus.mode_in)));
  assign wc_val  = (blk_len < rem_cnt) ? blk_len[4:0]
                                       : rem_cnt[4:0];
  assign wc_clr  = bus.out_len_load | bus.counter_rst;
  assign wc_load = bus.counter_load
                 & (state_q != DONE);

  // Capture, abort, clear and reload all pre-empt a shift.
  assign shift_ok = bus.shift_en & ~wc_zero
                  & ~bus.we_in & ~wc_clr & ~wc_load;

  word_down_counter #(.W(5)) word_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (wc_clr),
    .load_i     (wc_load),
    .load_val_i (wc_val),
    .dec_i      (shift_ok),
    .cnt_o      (wc_cnt),
    .zero_o     (wc_zero)
  );

  word_down_counter #(.W(LEN_W)) remaining (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (1'b0),
    .load_i     (bus.out_len_load),
    .load_val_i (bus.out_len_in),
    .dec_i      (shift_ok),
    .cnt_o      (rem_cnt),
    .zero_o     (rem_zero)
  );

  always_comb begin
    buf_d = buf_q;
    if (bus.we_in)
      buf_d = bus.mode_in ? (bus.state_in & MASK_256)
                          : bus.state_in;
    else if (shift_ok)
      buf_d = buf_q >> WORD_W;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      buf_q <= '0;
    else
      buf_q <= buf_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (bus.out_len_load) begin
      state_q <= (bus.out_len_in == '0) ? DONE : READY;
    end else begin
      unique case (state_q)
        READY:
          if (bus.we_in && bus.counter_load
              && !bus.counter_rst)
            state_q <= HOLD;
        HOLD:
          if (bus.counter_rst)
            state_q <= rem_zero ? DONE : READY;
          else if (shift_ok && wc_cnt == 5'd1)
            state_q <= (rem_cnt == LEN_W'(1)) ? DONE
                                              : READY;
        default: ;
      endcase
    end
  end

  assign bus.data_out   = buf_q[WORD_W-1:0];
  assign bus.empty      = wc_zero;
  assign bus.last_out   = (rem_cnt == LEN_W'(1)) & ~wc_zero;
  assign bus.done       = (state_q == DONE);
  assign bus.need_block = (state_q == READY);
endmodule

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer: vector table,
// directed squeeze sequences and randomized model compare.
module tb_output_buffer;
  localparam int WW = 64;
  localparam int RW = 1344;
  localparam int LW = 32;
  localparam int NL = 21;
  localparam int PI = 0, PR = 1, PH = 2, PD = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_buffer_if #(.WORD_W(WW), .RATE_W(RW), .LEN_W(LW)) bus();

  output_buffer #(.WORD_W(WW), .RATE_W(RW), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // reference model: lane list, pending words, total left, phase
  logic [WW-1:0] m_lane[NL];
  int m_cnt, m_rem, m_ph;

  typedef struct {
    bit oll; int len; bit md; bit we; bit cl; bit cr; bit sh;
    bit e_empty; bit e_last; bit e_done; bit e_need; int e_lane;
  } vec_t;
  vec_t tbl[15];
  int exp2[3] = '{17, 17, 6};

  function automatic logic [WW-1:0] ln(int seed, int i);
    return {16'(seed), 16'hA5A5, 32'(i)};
  endfunction

  function automatic logic [RW-1:0] mk(int seed);
    logic [RW-1:0] s;
    for (int i = 0; i < NL; i++) s[i*WW +: WW] = ln(seed, i);
    return s;
  endfunction

  function automatic logic [RW-1:0] rnd_state();
    logic [RW-1:0] s;
    for (int i = 0; i < RW/32; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_lane[i] = '0;
    m_cnt = 0; m_rem = 0; m_ph = PI;
  endtask

  task automatic model_step();
    int blk;
    bit ld_ok, clr, sh;
    blk   = bus.mode_in ? 17 : 21;
    ld_ok = bus.counter_load && m_ph != PD;
    clr   = bus.out_len_load || bus.counter_rst;
    sh    = bus.shift_en && m_cnt > 0 && !bus.we_in
            && !clr && !ld_ok;
    if (bus.we_in) begin
      for (int i = 0; i < NL; i++)
        m_lane[i] = (bus.mode_in && i >= 17) ? '0
                    : bus.state_in[i*WW +: WW];
    end else if (sh) begin
      for (int i = 0; i < NL-1; i++) m_lane[i] = m_lane[i+1];
      m_lane[NL-1] = '0;
    end
    if (bus.out_len_load) begin
      m_cnt = 0;
      m_rem = int'(bus.out_len_in);
      m_ph  = (m_rem == 0) ? PD : PR;
    end else if (bus.counter_rst) begin
      m_cnt = 0;
      if (m_ph == PH) m_ph = (m_rem == 0) ? PD : PR;
    end else if (ld_ok) begin
      m_cnt = (blk < m_rem) ? blk : m_rem;
      if (m_ph == PR && bus.we_in) m_ph = PH;
    end else if (sh) begin
      m_cnt--; m_rem--;
      if (m_ph == PH && m_cnt == 0)
        m_ph = (m_rem == 0) ? PD : PR;
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, ".data"},  bus.data_out, m_lane[0]);
    chk({tag, ".empty"}, 64'(bus.empty), 64'(m_cnt == 0));
    chk({tag, ".last"},  64'(bus.last_out),
        64'(m_rem == 1 && m_cnt > 0));
    chk({tag, ".done"},  64'(bus.done), 64'(m_ph == PD));
    chk({tag, ".need"},  64'(bus.need_block), 64'(m_ph == PR));
  endtask

  task automatic cyc(bit oll, int len, bit md, bit we, bit cl,
                     bit cr, bit sh, logic [RW-1:0] st);
    bus.out_len_load = oll;
    bus.out_len_in   = LW'(len);
    bus.mode_in      = md;
    bus.we_in        = we;
    bus.counter_load = cl;
    bus.counter_rst  = cr;
    bus.shift_en     = sh;
    bus.state_in     = st;
    model_step();
    @(posedge clk); #1;
    bus.out_len_load = 1'b0;
    bus.we_in        = 1'b0;
    bus.counter_load = 1'b0;
    bus.counter_rst  = 1'b0;
    bus.shift_en     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.out_len_load = 1'b0; bus.out_len_in = '0;
    bus.mode_in = 1'b0; bus.we_in = 1'b0;
    bus.counter_load = 1'b0; bus.counter_rst = 1'b0;
    bus.shift_en = 1'b0; bus.state_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.data",  bus.data_out, 0);
    chk("rst.empty", 64'(bus.empty), 1);
    chk("rst.last",  64'(bus.last_out), 0);
    chk("rst.done",  64'(bus.done), 0);
    chk("rst.need",  64'(bus.need_block), 0);
  endtask

  initial begin
    int k, n;
    logic [RW-1:0] st;
    logic [63:0] el;
    bit s;
    int r, len;
    bit oll, we, cl, cr, sh, md;

    //    oll len md we cl cr sh | empty last done need lane
    tbl[0]  = '{1, 3, 1, 0, 0, 0, 0,  1, 0, 0, 1, -1};
    tbl[1]  = '{0, 0, 1, 1, 1, 0, 0,  0, 0, 0, 0,  0};
    tbl[2]  = '{0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0,  1};
    tbl[3]  = '{0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  1};
    tbl[4]  = '{0, 0, 1, 0, 0, 0, 1,  0, 1, 0, 0,  2};
    tbl[5]  = '{0, 0, 1, 0, 0, 0, 1,  1, 0, 1, 0,  3};
    tbl[6]  = '{0, 0, 1, 0, 0, 0, 1,  1, 0, 1, 0,  3};
    tbl[7]  = '{0, 0, 1, 0, 1, 0, 0,  1, 0, 1, 0,  3};
    tbl[8]  = '{1, 0, 1, 0, 0, 0, 0,  1, 0, 1, 0,  3};
    tbl[9]  = '{1, 2, 0, 0, 0, 0, 0,  1, 0, 0, 1,  3};
    tbl[10] = '{0, 0, 0, 1, 1, 0, 1,  0, 0, 0, 0,  0};
    tbl[11] = '{0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 1,  0};
    tbl[12] = '{0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0,  0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0,  1};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 0,  2};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].oll, tbl[i].len, tbl[i].md, tbl[i].we,
          tbl[i].cl, tbl[i].cr, tbl[i].sh, mk(1));
      el = (tbl[i].e_lane < 0) ? 64'h0 : ln(1, tbl[i].e_lane);
      chk($sformatf("vec%0d.data", i), bus.data_out, el);
      chk($sformatf("vec%0d.empty", i), 64'(bus.empty),
          64'(tbl[i].e_empty));
      chk($sformatf("vec%0d.last", i), 64'(bus.last_out),
          64'(tbl[i].e_last));
      chk($sformatf("vec%0d.done", i), 64'(bus.done),
          64'(tbl[i].e_done));
      chk($sformatf("vec%0d.need", i), 64'(bus.need_block),
          64'(tbl[i].e_need));
    end

    // SHAKE128, one full block, shift held high
    do_reset();
    cyc(1, 21, 0, 0, 0, 0, 0, '0);
    st = mk(2);
    cyc(0, 0, 0, 1, 1, 0, 0, st);
    for (int i = 0; i < 21; i++) begin
      chk("t1.data", bus.data_out, ln(2, i));
      chk("t1.last", 64'(bus.last_out), 64'(i == 20));
      chk("t1.empty", 64'(bus.empty), 0);
      cyc(0, 0, 0, 0, 0, 0, 1, st);
    end
    chk("t1.empty_end", 64'(bus.empty), 1);
    chk("t1.done_end", 64'(bus.done), 1);

    // SHAKE256, 40 words over three blocks
    do_reset();
    cyc(1, 40, 1, 0, 0, 0, 0, '0);
    for (int b = 0; b < 3; b++) begin
      chk("t2.need", 64'(bus.need_block), 1);
      st = mk(10 + b);
      cyc(0, 0, 1, 1, 1, 0, 0, st);
      chk("t2.need_clr", 64'(bus.need_block), 0);
      n = 0;
      while (!bus.empty && n < 30) begin
        chk("t2.data", bus.data_out, ln(10 + b, n));
        chk("t2.last", 64'(bus.last_out), 64'(b == 2 && n == 5));
        chk("t2.done", 64'(bus.done), 0);
        cyc(0, 0, 1, 0, 0, 0, 1, st);
        n++;
      end
      chk("t2.words", 64'(n), 64'(exp2[b]));
    end
    chk("t2.done_end", 64'(bus.done), 1);
    chk("t2.need_end", 64'(bus.need_block), 0);

    // shift toggling, then shifts while empty
    do_reset();
    cyc(1, 30, 0, 0, 0, 0, 0, '0);
    st = mk(20);
    cyc(0, 0, 0, 1, 1, 0, 0, st);
    k = 0;
    for (int c = 0; c < 42; c++) begin
      s = (c % 2) == 0;
      el = (k < 21) ? ln(20, k) : 64'h0;
      chk("t3.data", bus.data_out, el);
      cyc(0, 0, 0, 0, 0, 0, s, st);
      if (s) k++;
    end
    chk("t3.empty", 64'(bus.empty), 1);
    chk("t3.need", 64'(bus.need_block), 1);
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 1, st);
    chk("t3.need_hold", 64'(bus.need_block), 1);
    st = mk(21);
    cyc(0, 0, 0, 1, 1, 0, 0, st);
    n = 0;
    while (!bus.empty && n < 30) begin
      chk("t3.data2", bus.data_out, ln(21, n));
      cyc(0, 0, 0, 0, 0, 0, 1, st);
      n++;
    end
    chk("t3.words2", 64'(n), 9);
    chk("t3.done", 64'(bus.done), 1);

    // capture and shift together: capture wins
    do_reset();
    cyc(1, 100, 0, 0, 0, 0, 0, '0);
    st = mk(30);
    cyc(0, 0, 0, 1, 1, 0, 0, st);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 1, st);
    chk("t4.pre", bus.data_out, ln(30, 3));
    st = mk(31);
    cyc(0, 0, 0, 1, 1, 0, 1, st);
    n = 0;
    while (!bus.empty && n < 30) begin
      chk("t4.data", bus.data_out, ln(31, n));
      cyc(0, 0, 0, 0, 0, 0, 1, st);
      n++;
    end
    chk("t4.words", 64'(n), 21);

    // asynchronous reset mid-block, then clean restart
    do_reset();
    cyc(1, 30, 0, 0, 0, 0, 0, '0);
    st = mk(40);
    cyc(0, 0, 0, 1, 1, 0, 0, st);
    repeat (7) cyc(0, 0, 0, 0, 0, 0, 1, st);
    chk("t6.pre", bus.data_out, ln(40, 7));
    #2 rst = 1'b1;
    #1;
    chk("t6.empty", 64'(bus.empty), 1);
    chk("t6.done", 64'(bus.done), 0);
    chk("t6.data", bus.data_out, 0);
    chk("t6.need", 64'(bus.need_block), 0);
    do_reset();
    cyc(1, 5, 1, 0, 0, 0, 0, '0);
    st = mk(41);
    cyc(0, 0, 1, 1, 1, 0, 0, st);
    n = 0;
    while (!bus.empty && n < 30) begin
      chk("t6.data2", bus.data_out, ln(41, n));
      cyc(0, 0, 1, 0, 0, 0, 1, st);
      n++;
    end
    chk("t6.words", 64'(n), 5);
    chk("t6.done2", 64'(bus.done), 1);

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      r   = $urandom_range(0, 99);
      oll = r < 4;
      len = $urandom_range(0, 45);
      md  = 1'($urandom_range(0, 1));
      we  = $urandom_range(0, 99) < ((m_ph == PR) ? 40 : 4);
      cl  = we ? ($urandom_range(0, 99) < 85)
               : ($urandom_range(0, 99) < 3);
      cr  = $urandom_range(0, 99) < 3;
      sh  = $urandom_range(0, 99) < 65;
      st  = we ? rnd_state() : '0;
      cyc(oll, len, md, we, cl, cr, sh, st);
      check_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
